// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the
// enumerations used by the fetch stage.
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        BR  = 2'b01,
        REG = 2'b10,
        BL  = 2'b11
    } pc_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic for the fetch stage: the sequential successor, the
// redirect target and the decision whether the ID-stage redirect is taken.
module pc_next
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] if_id_pc,
    input  logic            if_id_valid,
    input  logic            pc_load,
    input  logic [1:0]      pc_sel,
    input  logic            cond_true,
    input  logic [PC_W-1:0] br_offset,
    input  logic [PC_W-1:0] reg_target,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] target,
    output logic            redirect
);
    pc_sel_e sel;

    always_comb begin
        sel    = pc_sel_e'(pc_sel);
        seq_pc = pc + 16'd1;
        target = seq_pc;
        case (sel)
            BR, BL:  target = if_id_pc + br_offset;
            REG:     target = reg_target;
            default: target = seq_pc;
        endcase
        // A bubble in ID cannot redirect: its decoded controls are meaningless.
        redirect = pc_load && cond_true && (sel != SEQ) && if_id_valid;
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// RUN/HALT control FSM. Next-PC arithmetic lives in pc_next.
module ifetch_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                pc_load,
    input  logic [1:0]          pc_sel,
    input  logic                cond_true,
    input  logic [PC_W-1:0]     br_offset,
    input  logic [PC_W-1:0]     reg_target,
    input  logic                halt,
    input  logic                start,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [PC_W-1:0]     if_id_pc,
    output logic                if_id_valid,
    output logic                halted
);
    fetch_state_e        state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next_val;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [PC_W-1:0]     ifpc_reg, ifpc_next;
    logic                valid_reg, valid_next;

    logic [PC_W-1:0]     seq_pc;
    logic [PC_W-1:0]     target;
    logic                redirect;

    pc_next u_pc_next (
        .pc          (pc_reg),
        .if_id_pc    (ifpc_reg),
        .if_id_valid (valid_reg),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .cond_true   (cond_true),
        .br_offset   (br_offset),
        .reg_target  (reg_target),
        .seq_pc      (seq_pc),
        .target      (target),
        .redirect    (redirect)
    );

    always_comb begin
        state_next  = state_reg;
        pc_next_val = pc_reg;
        instr_next  = instr_reg;
        ifpc_next   = ifpc_reg;
        valid_next  = valid_reg;
        case (state_reg)
            RUN: begin
                if (halt) begin
                    state_next  = HALT;
                    pc_next_val = '0;
                    instr_next  = NOP_INSTR;
                    ifpc_next   = '0;
                    valid_next  = 1'b0;
                end else if (stall) begin
                    // Hold everything; a pending redirect is re-evaluated next cycle.
                    pc_next_val = pc_reg;
                end else if (redirect) begin
                    pc_next_val = target;
                    instr_next  = NOP_INSTR;
                    ifpc_next   = '0;
                    valid_next  = 1'b0;
                end else begin
                    pc_next_val = seq_pc;
                    instr_next  = imem_rdata;
                    ifpc_next   = seq_pc;
                    valid_next  = 1'b1;
                end
            end
            HALT: begin
                pc_next_val = '0;
                instr_next  = NOP_INSTR;
                ifpc_next   = '0;
                valid_next  = 1'b0;
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            ifpc_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next_val;
            instr_reg <= instr_next;
            ifpc_reg  <= ifpc_next;
            valid_reg <= valid_next;
        end
    end

    assign imem_addr   = pc_reg;
    assign if_id_instr = instr_reg;
    assign if_id_pc    = ifpc_reg;
    assign if_id_valid = valid_reg;
    assign halted      = (state_reg == HALT);
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the fetch stage.
module tb_ifetch_unit;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic        cond_true;
    logic [15:0] br_offset;
    logic [15:0] reg_target;
    logic        halt;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [15:0] m_pc, m_instr, m_ifpc;
    logic        m_valid, m_halted;

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .cond_true   (cond_true),
        .br_offset   (br_offset),
        .reg_target  (reg_target),
        .halt        (halt),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 16'h0; m_instr = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0;
    endtask

    // One clock of the fetch stage as described behaviourally.
    task automatic model_update();
        logic [15:0] tgt;
        if (m_halted) begin
            m_pc = 16'h0;
            model_bubble();
            if (start) m_halted = 1'b0;
        end else if (halt) begin
            m_pc = 16'h0;
            model_bubble();
            m_halted = 1'b1;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (pc_load && cond_true && pc_sel != 2'b00 && m_valid) begin
            tgt  = (pc_sel == 2'b10) ? reg_target : m_ifpc + br_offset;
            m_pc = tgt;
            model_bubble();
        end else begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc + 16'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   imem_addr,   m_pc);
        chk({tag, ".instr"},  if_id_instr, m_instr);
        chk({tag, ".ifpc"},   if_id_pc,    m_ifpc);
        chk({tag, ".valid"},  {15'b0, if_id_valid}, {15'b0, m_valid});
        chk({tag, ".halted"}, {15'b0, halted},      {15'b0, m_halted});
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; pc_load = 0; pc_sel = 2'b00; cond_true = 0;
        br_offset = 16'h0; reg_target = 16'h0; halt = 0; start = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sequential fetch
        step("seq0");
        chk("seq0_instr", if_id_instr, 16'hA000);
        chk("seq0_ifpc",  if_id_pc,    16'h0001);
        step("seq1");
        chk("seq1_instr", if_id_instr, 16'hA001);
        step("seq2");
        chk("seq2_instr", if_id_instr, 16'hA002);
        chk("seq2_ifpc",  if_id_pc,    16'h0003);
        step("seq3");
        chk("pre_br_ifpc", if_id_pc, 16'h0004);

        // Backward branch from if_id_pc=4 by -2
        pc_load = 1; pc_sel = 2'b01; cond_true = 1; br_offset = 16'hFFFE;
        step("branch");
        chk("branch_pc",    imem_addr,   16'h0002);
        chk("branch_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("branch_instr", if_id_instr, 16'h0000);
        idle_inputs();
        step("post_br0");
        step("post_br1");
        step("post_br2");
        chk("stall_start_pc", imem_addr, 16'h0005);

        // Two-cycle stall at pc=5
        stall = 1;
        step("stall0");
        chk("stall0_pc", imem_addr, 16'h0005);
        step("stall1");
        chk("stall1_pc", imem_addr, 16'h0005);
        chk("stall1_instr", if_id_instr, 16'hA004);
        stall = 0;
        step("resume");
        chk("resume_pc", imem_addr, 16'h0006);

        // BX held off by a one-cycle stall
        pc_load = 1; pc_sel = 2'b10; cond_true = 1; reg_target = 16'h0040; stall = 1;
        step("bx_stall");
        chk("bx_stall_pc", imem_addr, 16'h0006);
        stall = 0;
        step("bx_go");
        chk("bx_pc", imem_addr, 16'h0040);
        chk("bx_valid", {15'b0, if_id_valid}, 16'h0000);
        idle_inputs();
        step("post_bx");

        // Halt overrides stall and pc_load, then holds for 10 cycles
        halt = 1; stall = 1; pc_load = 1; pc_sel = 2'b01; cond_true = 1; br_offset = 16'h0010;
        step("halt");
        chk("halt_halted", {15'b0, halted}, 16'h0001);
        chk("halt_pc", imem_addr, 16'h0000);
        halt = 0;
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom);
            step("halt_hold");
        end
        chk("halt_hold_pc", imem_addr, 16'h0000);
        chk("halt_hold_valid", {15'b0, if_id_valid}, 16'h0000);
        idle_inputs();
        start = 1;
        step("start");
        chk("start_halted", {15'b0, halted}, 16'h0000);
        start = 0;
        step("first_fetch");
        chk("first_fetch_instr", if_id_instr, 16'hA000);

        // Wrap: redirect to 0xFFFF then fetch sequentially
        pc_load = 1; pc_sel = 2'b10; cond_true = 1; reg_target = 16'hFFFF;
        step("to_ffff");
        chk("ffff_pc", imem_addr, 16'hFFFF);
        idle_inputs();
        step("wrap");
        chk("wrap_pc", imem_addr, 16'h0000);
        chk("wrap_instr", if_id_instr, 16'h9FFF);

        // Asynchronous reset in the middle of a stalled cycle
        step("pre_rst");
        stall = 1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_addr",  imem_addr,   16'h0000);
        chk("arst_instr", if_id_instr, 16'h0000);
        chk("arst_ifpc",  if_id_pc,    16'h0000);
        chk("arst_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("arst_halted",{15'b0, halted},      16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 0;
        step("post_rst");
        chk("post_rst_instr", if_id_instr, 16'hA000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r          = 8'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            pc_load    = ($urandom_range(0, 2) == 0);
            pc_sel     = 2'($urandom);
            cond_true  = 1'($urandom);
            br_offset  = {{8{r[7]}}, r};
            reg_target = 16'($urandom);
            halt       = ($urandom_range(0, 40) == 0);
            start      = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port stall  input  1  load-use stall from the hazard unit; hold PC and IF/ID.
REQ-004 SHALL have port pc_load  input  1  redirect request from the ID-stage control decode.
REQ-005 SHALL have port pc_sel  input  2  redirect source: 00 sequential, 01 branch, 10 register (BX/BLX), 11 branch-and-link (BL).
REQ-006 SHALL have port cond_true  input  1  condition result for the ID-stage branch; B/BL drive 1.
REQ-007 SHALL have port br_offset  input  16  sign-extended sximm8 of the ID-stage instruction.
REQ-008 SHALL have port reg_target  input  16  forwarded register value for BX/BLX.
REQ-009 SHALL have port halt  input  1  ID-stage instruction is HALT (opcode 111).
REQ-010 SHALL have port start  input  1  single-cycle pulse that leaves HALT.
REQ-011 SHALL have port imem_addr  output  16  combinational instruction-memory address, equal to pc.
REQ-012 SHALL have port imem_rdata  input  16  combinational instruction-memory read data for imem_addr.
REQ-013 SHALL have port if_id_instr  output  16  registered instruction to ID.
REQ-014 SHALL have port if_id_pc  output  16  registered fetch address + 1; this is the link and branch base.
REQ-015 SHALL have port if_id_valid  output  1  1 = if_id_instr is a real instruction.
REQ-016 SHALL have port halted  output  1  1 while the FSM is in HALT.

Function
REQ-017 SHALL implement FSM states RUN and HALT.
REQ-018 SHALL give per-cycle actions in RUN the priority halt > stall > redirect > sequential.
REQ-019 In RUN, with halt=1, SHALL: set pc <= 0; set IF/ID <= bubble; enter HALT next cycle. halt SHALL override stall and pc_load.
REQ-020 In RUN, with halt=0 and stall=1, SHALL hold pc, if_id_instr, if_id_pc and if_id_valid unchanged. pc_load is ignored that cycle.
REQ-021 A redirect SHALL occur when pc_load=1, cond_true=1, pc_sel!=00 and if_id_valid=1.
REQ-022 On a redirect SHALL: set pc <= target; set IF/ID <= bubble, discarding the wrong-path fetch. Branch penalty is exactly one bubble.
REQ-023 SHALL compute target = if_id_pc + br_offset for pc_sel 01 or 11, and target = reg_target for pc_sel 10. Arithmetic is modulo 2^16; wrap past 16'hFFFF is legal.
REQ-024 pc_load=1 with pc_sel=00 or cond_true=0 SHALL behave as sequential.
REQ-025 Sequential operation SHALL: set pc <= pc + 1 (16'hFFFF wraps to 0); set if_id_instr <= imem_rdata; set if_id_pc <= pc + 1; set if_id_valid <= 1.
REQ-026 A bubble SHALL be: if_id_instr=16'h0000 (opcode 000, all-zero controls); if_id_pc=16'h0000; if_id_valid=0.
REQ-027 In HALT, SHALL hold pc=0 and IF/ID=bubble. stall, pc_load and halt are ignored.
REQ-028 In HALT, start=1 SHALL move the FSM to RUN next cycle. The first fetch (address 0) captures on the following edge.
REQ-029 start in RUN SHALL be ignored.
REQ-030 halted SHALL be registered and equal (state==HALT).
REQ-031 imem_addr SHALL equal pc combinationally in every state.

Reset
REQ-032 SHALL, while rst_n=0 and independent of clk, drive: pc=0, state=RUN, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0.
REQ-033 SHALL fetch address 0 on the first rising edge after rst_n deasserts; reset mid-stall or mid-redirect discards all pending actions.

Structure
REQ-034 SHALL take PC_W=16, INSTR_W=16, NOP_INSTR=16'h0000, the pc_sel encoding enum (SEQ, BR, REG, BL) and the fetch-state enum (RUN, HALT) from the shared package cpu_pkg.
REQ-035 SHALL place the next-PC/target selection in one combinational sub-module pc_next, instantiated once; PC, IF/ID registers and FSM remain in ifetch_unit.

Verification
REQ-036 SHALL verify sequential fetch: reset, imem returns 16'hA000+addr -> if_id_instr A000, A001, A002 on successive cycles with if_id_pc 1, 2, 3 and valid=1.
REQ-037 SHALL verify stall: stall=1 for 2 cycles when pc=5 -> imem_addr stays 5, IF/ID unchanged; resumes with addr 6.
REQ-038 SHALL verify branch: if_id_pc=4, br_offset=16'hFFFE, pc_sel=01, pc_load=1, cond_true=1 -> pc=2 next cycle, one bubble (valid=0, instr=0).
REQ-039 SHALL verify BX with stall: pc_sel=10, reg_target=16'h0040, stall=1 for 1 cycle then 0 -> redirect only after stall drops; pc=16'h0040.
REQ-040 SHALL verify halt/start: halt=1 with stall=1 -> halted=1, pc=0, bubble held 10 cycles despite pc_load; start pulse -> halted=0 next cycle, then fetch of addr 0.
REQ-041 SHALL verify wrap and async reset: pc=16'hFFFF sequential -> pc=0; rst_n low mid-cycle -> all outputs 0 before the next edge.
